// File: rtl/contact_result_drain_if.sv
// Capture and readout signal bundle for contact_result_drain: control-unit
// result words in, serialized 32-bit word stream and buffer status out.
interface contact_result_drain_if #(
  parameter int DATA_W = 32
);
  logic                     weout;
  logic signed [DATA_W-1:0] addressout;
  logic        [DATA_W-1:0] res0, res1, res2, res3, res4, res5, res6, res7;

  logic        [DATA_W-1:0] out_data;
  logic signed [DATA_W-1:0] out_tag;
  logic        [2:0]        out_index;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  logic                     full;
  logic        [4:0]        rec_count;
  logic                     overflow;

  modport master (
    input  weout, addressout, res0, res1, res2, res3, res4, res5, res6, res7,
    input  out_ready,
    output out_data, out_tag, out_index, out_valid, out_last,
    output full, rec_count, overflow
  );

  modport slave (
    output weout, addressout, res0, res1, res2, res3, res4, res5, res6, res7,
    output out_ready,
    input  out_data, out_tag, out_index, out_valid, out_last,
    input  full, rec_count, overflow
  );
endinterface

// File: rtl/contact_result_drain.sv
// Buffers 8-word contact result bundles from the sphere control unit and
// replays them one word per handshake toward the host readout stream.
module contact_result_drain #(
  parameter int DEPTH  = 4,
  parameter int WORDS  = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  contact_result_drain_if.master bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          IW       = 3;
  localparam logic [4:0]  DEPTH_C  = 5'(DEPTH);
  localparam logic [2:0]  LAST_IDX = 3'(WORDS - 1);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  logic        [DATA_W-1:0] res_w    [WORDS];
  logic        [DATA_W-1:0] mem      [DEPTH][WORDS];
  logic signed [DATA_W-1:0] tag_mem  [DEPTH];

  state_t                   state;
  logic                     weout_q;
  logic        [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nx;
  logic        [4:0]        count_r;
  logic                     overflow_r;

  logic        [DATA_W-1:0] data_p0;
  logic signed [DATA_W-1:0] tag_p0;
  logic        [2:0]        idx_p0, idx_nx;
  logic                     vld_p0;
  logic                     last_p0;

  logic push, accept, drop, hs, pop;

  always_comb begin
    res_w[0] = bus.res0;
    res_w[1] = bus.res1;
    res_w[2] = bus.res2;
    res_w[3] = bus.res3;
    res_w[4] = bus.res4;
    res_w[5] = bus.res5;
    res_w[6] = bus.res6;
    res_w[7] = bus.res7;
  end

  // Only a rising strobe captures; a held strobe is one bundle.
  assign push      = bus.weout & ~weout_q;
  assign accept    = push & (count_r < DEPTH_C);
  assign drop      = push & (count_r == DEPTH_C);
  assign hs        = vld_p0 & bus.out_ready;
  assign pop       = hs & (idx_p0 == LAST_IDX);
  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign idx_nx    = idx_p0 + 3'd1;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int w = 0; w < WORDS; w++) begin
        mem[wr_ptr][IW'(w)] <= res_w[IW'(w)];
      end
      tag_mem[wr_ptr] <= bus.addressout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weout_q    <= 1'b1;
      wr_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      weout_q <= bus.weout;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (drop) overflow_r <= 1'b1;
      case ({accept, pop})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Stage p0: registered emission state and output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      idx_p0  <= '0;
      data_p0 <= '0;
      tag_p0  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count_r != 5'd0) begin
            state   <= SEND;
            vld_p0  <= 1'b1;
            idx_p0  <= '0;
            last_p0 <= 1'b0;
            data_p0 <= mem[rd_ptr][0];
            tag_p0  <= tag_mem[rd_ptr];
          end
        end
        SEND: begin
          if (hs) begin
            if (idx_p0 != LAST_IDX) begin
              idx_p0  <= idx_nx;
              last_p0 <= (idx_nx == LAST_IDX);
              data_p0 <= mem[rd_ptr][idx_nx];
            end else begin
              rd_ptr  <= rd_ptr_nx;
              idx_p0  <= '0;
              last_p0 <= 1'b0;
              if (count_r > 5'd1) begin
                data_p0 <= mem[rd_ptr_nx][0];
                tag_p0  <= tag_mem[rd_ptr_nx];
              end else if (accept) begin
                // Next record is landing in RAM this very edge; take it from the inputs.
                data_p0 <= res_w[0];
                tag_p0  <= bus.addressout;
              end else begin
                state  <= IDLE;
                vld_p0 <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = data_p0;
  assign bus.out_tag   = tag_p0;
  assign bus.out_index = idx_p0;
  assign bus.out_valid = vld_p0;
  assign bus.out_last  = last_p0;
  assign bus.full      = (count_r == DEPTH_C);
  assign bus.rec_count = count_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_contact_result_drain.sv
// Directed bench for contact_result_drain: stimulus queues expected words,
// a negedge monitor pops and compares on every handshake.
module tb_contact_result_drain;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  contact_result_drain_if #(.DATA_W(32)) bus ();

  contact_result_drain #(.DEPTH(4), .WORDS(8), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] tag;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [31:0] base, input logic [31:0] tag);
    bus.res0 = base;       bus.res1 = base + 32'd1;
    bus.res2 = base + 32'd2; bus.res3 = base + 32'd3;
    bus.res4 = base + 32'd4; bus.res5 = base + 32'd5;
    bus.res6 = base + 32'd6; bus.res7 = base + 32'd7;
    bus.addressout = tag;
  endtask

  task automatic push_exp(input logic [31:0] base, input logic [31:0] tag);
    for (int i = 0; i < 8; i++)
      q.push_back('{data: base + 32'(i), tag: tag, idx: 3'(i), last: (i == 7)});
  endtask

  // One-cycle strobe pulse; expected words queued only if capture is expected.
  task automatic pulse(input logic [31:0] base, input logic [31:0] tag, input bit expect_cap);
    set_bundle(base, tag);
    if (expect_cap) push_exp(base, tag);
    bus.weout = 1'b1;
    tick();
    bus.weout = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 300), 32'd1);
  endtask

  // Scoreboard monitor plus hold-stability check while the reader stalls.
  logic        held = 1'b0;
  logic [31:0] held_data;
  logic [2:0]  held_idx;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && bus.out_valid) begin
        chk("hold_data", bus.out_data, held_data);
        chk("hold_index", 32'(bus.out_index), 32'(held_idx));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", bus.out_data);
        end else begin
          e = q.pop_front();
          chk("word_data", bus.out_data, e.data);
          chk("word_tag", bus.out_tag, e.tag);
          chk("word_index", 32'(bus.out_index), 32'(e.idx));
          chk("word_last", 32'(bus.out_last), 32'(e.last));
        end
        held = 1'b0;
      end else if (bus.out_valid) begin
        held      = 1'b1;
        held_data = bus.out_data;
        held_idx  = bus.out_index;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.weout = 1'b1;
    bus.out_ready = 1'b1;
    set_bundle(32'h0, 32'h0);

    // Reset state, with strobe held high across release.
    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_index", 32'(bus.out_index), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_tag", bus.out_tag, 32'd0);
    chk("rst_count", 32'(bus.rec_count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("held_strobe_no_capture", 32'(bus.rec_count), 32'd0);
    bus.weout = 1'b0;
    tick();

    // Single bundle with latency and framing checks.
    set_bundle(32'h10, 32'h0);
    push_exp(32'h10, 32'h0);
    bus.weout = 1'b1;
    tick();
    bus.weout = 1'b0;
    chk("lat_count_after_capture", 32'(bus.rec_count), 32'd1);
    chk("lat_valid_after_capture", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_valid_second_edge", 32'(bus.out_valid), 32'd1);
    chk("lat_first_word", bus.out_data, 32'h10);
    for (int i = 0; i < 7; i++) tick();
    chk("t1_last_word", bus.out_data, 32'h17);
    chk("t1_last_flag", 32'(bus.out_last), 32'd1);
    tick();
    chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_idle_count", 32'(bus.rec_count), 32'd0);

    // Strobe held five cycles captures one bundle.
    set_bundle(32'h20, 32'h1234);
    push_exp(32'h20, 32'h1234);
    bus.weout = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("held5_count", 32'(bus.rec_count), 32'd1);
    bus.weout = 1'b0;
    drain("held5_drain");
    chk("held5_count_end", 32'(bus.rec_count), 32'd0);

    // Fill to DEPTH with a stalled reader, then overflow, then burst out.
    bus.out_ready = 1'b0;
    pulse(32'h100, 32'h1, 1'b1);
    pulse(32'h200, 32'hFFFF_FFFB, 1'b1);
    pulse(32'h300, 32'h3, 1'b1);
    pulse(32'h400, 32'h8000_0000, 1'b1);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.rec_count), 32'd4);
    chk("fill_no_overflow", 32'(bus.overflow), 32'd0);
    pulse(32'h500, 32'h5, 1'b0);
    chk("drop_overflow", 32'(bus.overflow), 32'd1);
    chk("drop_count", 32'(bus.rec_count), 32'd4);
    bus.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    chk("burst_no_bubble", 32'(n), 32'd32);
    tick();
    chk("burst_count_end", 32'(bus.rec_count), 32'd0);
    chk("burst_overflow_sticky", 32'(bus.overflow), 32'd1);
    drain("burst_drain");

    // Reader toggling ready every cycle during a record.
    pulse(32'h600, 32'h6, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    bus.out_ready = 1'b1;
    drain("toggle_drain");

    // Push lands on the same edge as the pop of the head's last word, count=2.
    bus.out_ready = 1'b0;
    pulse(32'h700, 32'h7, 1'b1);
    pulse(32'h800, 32'h8, 1'b1);
    chk("coin_count_before", 32'(bus.rec_count), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    set_bundle(32'h900, 32'h9);
    push_exp(32'h900, 32'h9);
    bus.weout = 1'b1;
    tick();
    bus.weout = 1'b0;
    chk("coin_count_after", 32'(bus.rec_count), 32'd2);
    chk("coin_next_record", bus.out_data, 32'h800);
    drain("coin_drain");

    // Reset mid-record with strobe high.
    pulse(32'hA00, 32'hA, 1'b1);
    n = 0;
    while (!(bus.out_valid && bus.out_index == 3'd3) && n < 20) begin
      tick();
      n++;
    end
    chk("mid_reach_index3", 32'(n < 20), 32'd1);
    rst = 1'b1;
    bus.weout = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_count", 32'(bus.rec_count), 32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("mid_rst_index", 32'(bus.out_index), 32'd0);
    tick(); tick(); tick();
    chk("mid_no_capture_held", 32'(bus.rec_count), 32'd0);
    chk("mid_no_capture_valid", 32'(bus.out_valid), 32'd0);
    bus.weout = 1'b0;
    tick();
    set_bundle(32'hB00, 32'hFFFF_FF00);
    push_exp(32'hB00, 32'hFFFF_FF00);
    bus.weout = 1'b1;
    tick();
    bus.weout = 1'b0;
    chk("mid_recapture_count", 32'(bus.rec_count), 32'd1);
    drain("mid_drain");
    chk("final_count", 32'(bus.rec_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/contact_result_drain.md
Name: contact_result_drain

Overview:
- Sits directly downstream of the dCollide sphere control unit.
- Captures each 8-word contact result bundle (out0..out7) on the control unit's output write strobe (weout), together with its output address (addressout).
- Holds captured bundles in a small record FIFO.
- Serializes each record one 32-bit word at a time onto a valid/ready stream toward the host/JTAG readout, so slow readers never lose a bundle while buffer space remains.

Parameters:
- DEPTH, 4, number of 8-word records buffered; power of two, 2..16.
- WORDS, 8, words per record; fixed to match the control unit's out0..out7.
- DATA_W, 32, width of each result word and of the record tag.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- weout  input  1  record write strobe from control unit; may stay high for several cycles.
- addressout  input  32  signed output address from control unit; stored as the record tag.
- res0..res7  input  32 each  result words, sampled at capture.
- out_data  output  32  current serialized word.
- out_tag  output  32  tag of the record currently being emitted.
- out_index  output  3  word index 0..7 within the record.
- out_valid  output  1  out_data/out_tag/out_index are valid.
- out_ready  input  1  consumer accepts the word this cycle.
- out_last  output  1  high with word index 7.
- full  output  1  count == DEPTH.
- rec_count  output  5  records held, including the one being emitted (0..DEPTH).
- overflow  output  1  sticky; a bundle was dropped.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_last=0, out_index=0, out_data=0, out_tag=0.
  - rec_count=0, full=0, overflow=0; read/write pointers 0.
  - Strobe history register weout_q=1, so a weout held high across reset release does not capture.
  - Reset mid-record discards all buffered data; FIFO RAM contents need not be cleared.
- Capture:
  - push = weout & ~weout_q (rising edge only). weout_q <= weout every cycle.
  - When push and registered rec_count < DEPTH: store res0..res7 and addressout at the write pointer, then increment the write pointer (wraps modulo DEPTH).
  - When push and rec_count == DEPTH: drop the bundle and set overflow. This holds even if the last word of the head record is popped in that same cycle.
  - overflow clears only on rst.
- Emission state machine:
  - IDLE:
    - out_valid=0.
    - If rec_count > 0, go to SEND with out_index=0, and load out_data and out_tag from the head record.
  - SEND:
    - out_valid=1. Outputs are registered and hold stable while out_ready=0.
    - Handshake occurs when out_valid & out_ready.
    - Handshake with out_index < 7: out_index+1, load the next word.
    - Handshake with out_index == 7 (out_last=1): pop the record and advance the read pointer. Then:
      - if more records remain (rec_count after pop > 0), stay in SEND with index 0 of the next record, with no bubble cycle;
      - otherwise go to IDLE.
- Latency:
  - Capture at edge N into an empty FIFO: rec_count=1 after N.
  - out_valid=1 after edge N+1, with word 0.
  - With out_ready held high, one word per cycle; a full record takes 8 cycles.
- rec_count update: +1 on accepted push, -1 on pop, unchanged when both happen in the same cycle.
- Arithmetic:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - rec_count never exceeds DEPTH.
  - The tag is stored bit-exact; signed addressout values, including negative ones, pass through unchanged.

Test Plan:
- Reset, then weout pulse with res0..res7=0x10..0x17 and addressout=0, out_ready=1 -> out_valid rises 2 edges after the pulse; words 0x10..0x17 on 8 consecutive cycles, out_index 0..7, out_last only on 0x17, out_tag=0.
- weout held high 5 cycles with one bundle -> exactly one record captured; rec_count=1, then 0 after 8 words.
- out_ready=0, 5 distinct bundles with DEPTH=4 -> full=1 after the 4th, 5th dropped, overflow=1; then out_ready=1 -> 32 words from bundles 1-4 in order, no bubble between records.
- out_ready toggling 1,0,1,0 during a record -> each word held stable while out_ready=0; no word skipped or repeated.
- Push coinciding with pop of the last word, with count=2 -> rec_count stays 2; new record emitted after the remaining one.
- rst asserted mid-record (out_index=3) with weout high -> next cycle out_valid=0, rec_count=0, overflow=0; no capture until weout falls and rises again.
